// File: rtl/zircon_ip_tx_udp_hdr.sv
// UDP transmit header inserter: prepends an 8-byte UDP header (ports, length,
// checksum) to each payload packet, or drops packets whose length overflows udp_len.
module zircon_ip_tx_udp_hdr #(
    parameter int DATA_W = 64,
    parameter int USER_W = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         s_axis_meta_tdata,
    input  logic                s_axis_meta_tvalid,
    output logic                s_axis_meta_tready,
    input  logic [DATA_W-1:0]   s_axis_pkt_tdata,
    input  logic [DATA_W/8-1:0] s_axis_pkt_tkeep,
    input  logic                s_axis_pkt_tvalid,
    input  logic                s_axis_pkt_tlast,
    input  logic [USER_W-1:0]   s_axis_pkt_tuser,
    output logic                s_axis_pkt_tready,
    input  logic [15:0]         cfg_src_port,
    input  logic [15:0]         cfg_dst_port,
    input  logic [15:0]         cfg_pseudo_sum,
    output logic [DATA_W-1:0]   m_axis_pkt_tdata,
    output logic [DATA_W/8-1:0] m_axis_pkt_tkeep,
    output logic                m_axis_pkt_tvalid,
    input  logic                m_axis_pkt_tready,
    output logic                m_axis_pkt_tlast,
    output logic [USER_W-1:0]   m_axis_pkt_tuser,
    output logic                status_drop
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int ENT_W  = DATA_W + KEEP_W + 1 + USER_W;

    if (DATA_W != 64) begin : g_width_check
        $error("zircon_ip_tx_udp_hdr: DATA_W must be 64");
    end

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

    state_t             r_state;
    logic               r_run;
    logic [1:0]         r_cnt;
    logic [ENT_W-1:0]   r_buf0;
    logic [ENT_W-1:0]   r_buf1;

    logic               w_meta_hs;
    logic               w_pkt_hs;
    logic               w_in_pkt;
    logic               w_oversize;
    logic               w_push;
    logic               w_pop;
    logic               w_wr_slot;
    logic [15:0]        w_len;
    logic [15:0]        w_psum;
    logic [15:0]        w_udp_len;
    logic [18:0]        w_sum;
    logic [16:0]        w_fold;
    logic [15:0]        w_fold2;
    logic [15:0]        w_cksum_raw;
    logic [15:0]        w_cksum;
    logic [63:0]        w_hdr_data;
    logic [ENT_W-1:0]   w_hdr_ent;
    logic [ENT_W-1:0]   w_pkt_ent;
    logic [ENT_W-1:0]   w_push_ent;

    assign w_len      = s_axis_meta_tdata[15:0];
    assign w_psum     = s_axis_meta_tdata[31:16];
    assign w_oversize = w_len > 16'd65527;
    assign w_udp_len  = w_len + 16'd8;

    // udp_len enters the checksum twice: once in the pseudo-header, once in the UDP header
    assign w_sum = {3'b000, cfg_pseudo_sum} + {3'b000, cfg_src_port} + {3'b000, cfg_dst_port}
                 + {2'b00, w_udp_len, 1'b0} + {3'b000, w_psum};
    assign w_fold      = {1'b0, w_sum[15:0]} + {14'd0, w_sum[18:16]};
    assign w_fold2     = w_fold[15:0] + {15'd0, w_fold[16]};
    assign w_cksum_raw = ~w_fold2;
    assign w_cksum     = (w_cksum_raw == 16'h0000) ? 16'hFFFF : w_cksum_raw;

    assign w_hdr_data = {w_cksum[7:0], w_cksum[15:8], w_udp_len[7:0], w_udp_len[15:8],
                         cfg_dst_port[7:0], cfg_dst_port[15:8], cfg_src_port[7:0], cfg_src_port[15:8]};
    assign w_hdr_ent  = {w_hdr_data, {KEEP_W{1'b1}}, 1'b0, {USER_W{1'b0}}};
    assign w_pkt_ent  = {s_axis_pkt_tdata, s_axis_pkt_tkeep, s_axis_pkt_tlast, s_axis_pkt_tuser};

    assign w_in_pkt           = (r_state == HDR) || (r_state == PAYLOAD);
    assign s_axis_meta_tready = r_run && (r_state == IDLE) && (r_cnt != 2'd2);
    assign s_axis_pkt_tready  = (r_state == DROP) || (w_in_pkt && (r_cnt != 2'd2));

    assign w_meta_hs  = s_axis_meta_tvalid && s_axis_meta_tready;
    assign w_pkt_hs   = s_axis_pkt_tvalid && s_axis_pkt_tready;
    assign w_pop      = (r_cnt != 2'd0) && m_axis_pkt_tready;
    assign w_push     = (w_meta_hs && !w_oversize) || (w_pkt_hs && w_in_pkt);
    assign w_push_ent = w_meta_hs ? w_hdr_ent : w_pkt_ent;
    assign w_wr_slot  = (r_cnt == 2'd1) && !w_pop;

    assign m_axis_pkt_tvalid = r_cnt != 2'd0;
    assign m_axis_pkt_tdata  = r_buf0[ENT_W-1 -: DATA_W];
    assign m_axis_pkt_tkeep  = r_buf0[USER_W+1 +: KEEP_W];
    assign m_axis_pkt_tlast  = r_buf0[USER_W];
    assign m_axis_pkt_tuser  = r_buf0[USER_W-1:0];

    // The header is queued into the skid buffer at the meta handshake, so HDR
    // lasts one cycle and payload may queue up behind the not-yet-sent header.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_run       <= 1'b0;
            r_cnt       <= 2'd0;
            r_buf0      <= '0;
            r_buf1      <= '0;
            status_drop <= 1'b0;
        end else begin
            r_run       <= 1'b1;
            status_drop <= w_meta_hs && w_oversize;
            if (w_pop) begin
                r_buf0 <= r_buf1;
            end
            if (w_push) begin
                if (w_wr_slot) begin
                    r_buf1 <= w_push_ent;
                end else begin
                    r_buf0 <= w_push_ent;
                end
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            case (r_state)
                IDLE: begin
                    if (w_meta_hs) begin
                        r_state <= w_oversize ? DROP : HDR;
                    end
                end
                HDR: begin
                    r_state <= (w_pkt_hs && s_axis_pkt_tlast) ? IDLE : PAYLOAD;
                end
                PAYLOAD, DROP: begin
                    if (w_pkt_hs && s_axis_pkt_tlast) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
